// File: rtl/spectro_pkg.sv
// Shared constants and capture-state encoding for the spectrometer channel deserializer.
package spectro_pkg;

  localparam int WORD_W_DEF = 12;
  localparam int CHAN_W     = 4;
  localparam int NUM_CHAN   = 16;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_SHIFT = 1'b1
  } cap_state_e;

endpackage

// File: rtl/spectro_deserializer_fifo.sv
// Synchronous FIFO for captured channel words; a push into a full buffer succeeds
// only when a pop happens in the same cycle. Head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/spectro_deserializer.sv
// Serial-to-parallel capture of sequencer channel slots into an output buffer.
// Optional per-word even parity output enabled by SPECTRO_DESER_PARITY_EN.
module spectro_deserializer
  import spectro_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sl,
  input  logic [CHAN_W-1:0] selection,
  input  logic              frame_rst,
  input  logic              sdata,
  output logic [WORD_W-1:0] out_word,
  output logic [CHAN_W-1:0] out_chan,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SPECTRO_DESER_PARITY_EN
  output logic              out_parity,
`endif
  output logic              frame_done,
  output logic              overflow,
  output logic              seq_err,
  input  logic              clr_flags
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
`ifdef SPECTRO_DESER_PARITY_EN
  localparam int ENT_W = WORD_W + CHAN_W + 1;
`else
  localparam int ENT_W = WORD_W + CHAN_W;
`endif

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0] shreg_q, shreg_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              frame_done_q, overflow_q, overflow_d, seq_err_q, seq_err_d;
  logic              push, abort, pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0] push_word;
  logic [ENT_W-1:0]  push_ent, head_ent;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CAP_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      chan_q    <= chan_d;
    end
  end

  // frame_rst beats sl; sl restarts capture from any state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    chan_d    = chan_q;
    if (frame_rst) begin
      state_d   = CAP_IDLE;
      bit_cnt_d = '0;
    end else if (sl) begin
      state_d   = CAP_SHIFT;
      bit_cnt_d = CNT_W'(1);
      shreg_d   = (WORD_W-1)'(sdata);
      chan_d    = selection;
    end else if (state_q == CAP_SHIFT) begin
      if (bit_cnt_q == LAST_BIT) begin
        state_d   = CAP_IDLE;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = {shreg_q[WORD_W-3:0], sdata};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    push  = 1'b0;
    abort = 1'b0;
    if (state_q == CAP_SHIFT) begin
      abort = frame_rst || sl;
      push  = !abort && (bit_cnt_q == LAST_BIT);
    end
  end

  assign push_word = {shreg_q, sdata};
`ifdef SPECTRO_DESER_PARITY_EN
  assign push_ent   = {^push_word, chan_q, push_word};
  assign out_parity = head_ent[ENT_W-1];
`else
  assign push_ent   = {chan_q, push_word};
`endif

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_word  = head_ent[WORD_W-1:0];
  assign out_chan  = head_ent[WORD_W +: CHAN_W];

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_ent),
    .pop_i   (pop),
    .rdata_o (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Flag set events take priority over clr_flags.
  always_comb begin
    seq_err_d  = abort ? 1'b1 : (clr_flags ? 1'b0 : seq_err_q);
    overflow_d = (push && fifo_full && !pop) ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      frame_done_q <= frame_rst;
      overflow_q   <= overflow_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_spectro_deserializer.sv
// Self-checking bench for spectro_deserializer: slot-level reference model,
// vector table, directed corner sequences and randomized traffic.
module tb_spectro_deserializer;
  localparam int W     = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, sl, frame_rst, sdata, out_ready, clr_flags;
  logic [3:0]    selection, out_chan;
  logic [W-1:0]  out_word;
  logic          out_valid, frame_done, overflow, seq_err;
`ifdef SPECTRO_DESER_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  spectro_deserializer #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .sl         (sl),
    .selection  (selection),
    .frame_rst  (frame_rst),
    .sdata      (sdata),
    .out_word   (out_word),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef SPECTRO_DESER_PARITY_EN
    .out_parity (out_parity),
`endif
    .frame_done (frame_done),
    .overflow   (overflow),
    .seq_err    (seq_err),
    .clr_flags  (clr_flags)
  );

  typedef struct {
    logic [3:0]   chan;
    logic [W-1:0] word;
  } ent_t;

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] word;
    logic [3:0]   exp_chan;
    logic [W-1:0] exp_word;
    logic         exp_par;
  } vec_t;

  ent_t mq[$];
  logic m_ovf, m_serr, m_fdone;
  logic partial_pending;
  int   rdy_mode;   // 0: always ready, 1: never ready, 2: random
  int   n_chk = 0, n_pass = 0;
  int   deliv_cnt, fd_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_outputs();
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_word", int'(out_word), int'(mq[0].word));
      chk("out_chan", int'(out_chan), int'(mq[0].chan));
`ifdef SPECTRO_DESER_PARITY_EN
      chk("out_parity", int'(out_parity), int'(^mq[0].word));
`endif
    end
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("seq_err", int'(seq_err), int'(m_serr));
    chk("frame_done", int'(frame_done), int'(m_fdone));
  endtask

  // One clock: drive inputs, check the model, advance both model and DUT.
  task automatic cyc(input logic s, input logic [3:0] sel, input logic b, input logic f,
                     input logic clr, input logic push, input logic [3:0] pch,
                     input logic [W-1:0] pw, input logic abrt);
    logic pop, full;
    sl = s; selection = sel; sdata = b; frame_rst = f; clr_flags = clr;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    check_outputs();
    if (frame_done) fd_cnt++;
    pop  = (mq.size() != 0) && out_ready;
    full = (mq.size() == DEPTH);
    @(posedge clk); #1;
    if (pop) begin
      void'(mq.pop_front());
      deliv_cnt++;
    end
    if (push && full && !pop) m_ovf = 1'b1;
    else begin
      if (push) mq.push_back('{chan: pch, word: pw});
      if (clr) m_ovf = 1'b0;
    end
    if (abrt) m_serr = 1'b1;
    else if (clr) m_serr = 1'b0;
    m_fdone = f;
  endtask

  task automatic slot(input logic [3:0] sel, input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++)
      cyc(i == 0, sel, w[W-1-i], 1'b0, 1'b0, (n == W) && (i == W-1), sel, w,
          (i == 0) && partial_pending);
    partial_pending = (n < W);
  endtask

  task automatic frame(input logic clr);
    cyc(1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b1, clr, 1'b0, 4'd0, '0, partial_pending);
    partial_pending = 1'b0;
  endtask

  task automatic idle(input int k, input logic clr);
    for (int i = 0; i < k; i++)
      cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, clr,
          1'b0, 4'd0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; sl = 1'b0; frame_rst = 1'b0; clr_flags = 1'b0; sdata = 1'b1;
    selection = 4'd9; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0; m_serr = 1'b0; m_fdone = 1'b0; partial_pending = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_word"},  int'(out_word),   0);
    chk({tag, "_chan"},  int'(out_chan),   0);
    chk({tag, "_valid"}, int'(out_valid),  0);
    chk({tag, "_fdone"}, int'(frame_done), 0);
    chk({tag, "_ovf"},   int'(overflow),   0);
    chk({tag, "_serr"},  int'(seq_err),    0);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{4'd5,  12'hA5C, 4'd5,  12'hA5C, 1'b0};
    vt[1] = '{4'd0,  12'h000, 4'd0,  12'h000, 1'b0};
    vt[2] = '{4'd15, 12'hFFF, 4'd15, 12'hFFF, 1'b0};
    vt[3] = '{4'd9,  12'h3C3, 4'd9,  12'h3C3, 1'b0};
    vt[4] = '{4'd1,  12'h007, 4'd1,  12'h007, 1'b1};
    vt[5] = '{4'd2,  12'h003, 4'd2,  12'h003, 1'b0};
    vt[6] = '{4'd12, 12'h800, 4'd12, 12'h800, 1'b1};
    vt[7] = '{4'd7,  12'h001, 4'd7,  12'h001, 1'b1};
    rdy_mode = 0; deliv_cnt = 0; fd_cnt = 0;

    do_reset();
    check_zero("rst");

    // Single slot latency: nothing visible after 11 bits, word after the 12th.
    for (int i = 0; i < W-1; i++)
      cyc(i == 0, 4'd5, vt[0].word[W-1-i], 1'b0, 1'b0, 1'b0, 4'd5, '0, 1'b0);
    chk("lat_valid_11", int'(out_valid), 0);
    cyc(1'b0, 4'd3, vt[0].word[0], 1'b0, 1'b0, 1'b1, 4'd5, vt[0].word, 1'b0);
    chk("lat_valid_12", int'(out_valid), 1);
    chk("lat_word", int'(out_word), 'hA5C);
    chk("lat_chan", int'(out_chan), 5);
    idle(2, 1'b0);

    // Vector table, one slot each with the consumer ready.
    for (int v = 0; v < 8; v++) begin
      slot(vt[v].sel, vt[v].word, W);
      chk("vec_valid", int'(out_valid), 1);
      chk("vec_word", int'(out_word), int'(vt[v].exp_word));
      chk("vec_chan", int'(out_chan), int'(vt[v].exp_chan));
`ifdef SPECTRO_DESER_PARITY_EN
      chk("vec_parity", int'(out_parity), int'(vt[v].exp_par));
`endif
      idle(1, 1'b0);
    end

    // Full frame with the consumer ready.
    deliv_cnt = 0; fd_cnt = 0;
    for (int c = 0; c < 16; c++) slot(4'(c), 12'h100 + 12'(c), W);
    frame(1'b0);
    idle(3, 1'b0);
    chk("frame_words", deliv_cnt, 16);
    chk("frame_done_cnt", fd_cnt, 1);
    chk("frame_ovf", int'(overflow), 0);
    chk("frame_serr", int'(seq_err), 0);

    // Backpressure across a whole frame, then drain.
    rdy_mode = 1;
    for (int c = 0; c < 16; c++) slot(4'(c), 12'h100 + 12'(c), W);
    frame(1'b0);
    idle(2, 1'b0);
    chk("bp_ovf", int'(overflow), 1);
    chk("bp_head_chan", int'(out_chan), 0);
    chk("bp_head_word", int'(out_word), 'h100);
    rdy_mode = 0; deliv_cnt = 0;
    idle(6, 1'b0);
    chk("bp_drained", deliv_cnt, 4);
    chk("bp_valid_low", int'(out_valid), 0);
    idle(1, 1'b1);
    chk("bp_ovf_clr", int'(overflow), 0);

    // Early sl after 5 bits, then a clean word, then clear.
    slot(4'd2, 12'hFFF, 5);
    slot(4'd7, 12'h3C3, W);
    chk("early_serr", int'(seq_err), 1);
    chk("early_word", int'(out_word), 'h3C3);
    chk("early_chan", int'(out_chan), 7);
    idle(2, 1'b0);
    idle(1, 1'b1);
    chk("early_clr", int'(seq_err), 0);

    // Abort by frame_rst with clr_flags in the same cycle: set wins.
    slot(4'd4, 12'h555, 4);
    frame(1'b1);
    chk("setwins_serr", int'(seq_err), 1);
    idle(1, 1'b1);

    // sl together with frame_rst: no capture begins, following bits ignored.
    cyc(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    idle(W + 2, 1'b0);
    chk("slfr_valid", int'(out_valid), 0);
    chk("slfr_serr", int'(seq_err), 0);

    // Reset after 7 bits of a slot.
    slot(4'd3, 12'hABC, 7);
    do_reset();
    check_zero("midrst");
    idle(W, 1'b0);
    chk("midrst_nowrd", int'(out_valid), 0);
    slot(4'd11, 12'h5A3, W);
    chk("midrst_word", int'(out_word), 'h5A3);
    chk("midrst_chan", int'(out_chan), 11);
    idle(2, 1'b0);

    // Randomized traffic against the model.
    rdy_mode = 2;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (partial_pending) begin
        if (r < 75) slot(4'($urandom_range(0, 15)), 12'($urandom), W);
        else        frame(1'($urandom_range(0, 1)));
      end else if (r < 60) slot(4'($urandom_range(0, 15)), 12'($urandom), W);
      else if (r < 72) slot(4'($urandom_range(0, 15)), 12'($urandom), $urandom_range(1, W-1));
      else if (r < 80) frame(1'b0);
      else if (r < 86) idle(1, 1'b1);
      else idle($urandom_range(1, 6), 1'b0);
    end
    if (partial_pending) frame(1'b0);
    rdy_mode = 0;
    idle(DEPTH + 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spectro_deserializer.md
SPECTRO_DESERIALIZER -- requirements
Module: spectro_deserializer

Interface
REQ-001 Parameter WORD_W, default 12, bits per channel word; equals the 12-cycle channel slot of the scan sequencer.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sl  input  1  slot-start strobe from sequencer, high for one cycle at the start of each channel slot.
REQ-006 selection  input  4  channel index from sequencer; 0 = RTC, 1..15 = CH1..CH15.
REQ-007 frame_rst  input  1  end-of-frame strobe from sequencer, one cycle.
REQ-008 sdata  input  1  serial data from the selected channel's shift register, MSB first.
REQ-009 out_word  output  WORD_W  head-of-buffer data word.
REQ-010 out_chan  output  4  channel index of out_word.
REQ-011 out_valid  output  1  buffer non-empty.
REQ-012 out_ready  input  1  consumer accepts; pop when out_valid && out_ready.
REQ-013 frame_done  output  1  one-cycle pulse, cycle after frame_rst.
REQ-014 overflow  output  1  sticky: word dropped because buffer full.
REQ-015 seq_err  output  1  sticky: slot aborted before WORD_W bits.
REQ-016 clr_flags  input  1  clears overflow and seq_err.

Function
REQ-017 Capture FSM states IDLE, SHIFT; sdata sampled every cycle of a slot, beginning with the sl cycle (that bit = MSB).
REQ-018 IDLE + sl: sample bit, bit_cnt=1, latch selection, go SHIFT; IDLE without sl: ignore sdata.
REQ-019 SHIFT: shift in sdata, bit_cnt+1; on cycle bit_cnt==WORD_W-1, write {shreg, sdata} plus latched channel to buffer, go IDLE.
REQ-020 Latency: out_valid high the cycle after the last bit is sampled when buffer was empty.
REQ-021 sl while SHIFT with bit_cnt<WORD_W: discard partial word, set seq_err, restart capture in the same cycle per REQ-018.
REQ-022 frame_rst while SHIFT: discard partial word, set seq_err, go IDLE; frame_rst in IDLE: no error.
REQ-023 sl and frame_rst in the same cycle: frame_rst wins, no capture starts.
REQ-024 Push while full and no pop: word dropped, overflow set, buffer unchanged.
REQ-025 Push and pop in the same cycle while full: both succeed, occupancy unchanged.
REQ-026 out_word/out_chan stable while out_valid && !out_ready; FIFO order preserved.
REQ-027 clr_flags and a same-cycle flag-set event: set wins.

Reset
REQ-028 On reset: FSM IDLE, bit_cnt=0, buffer empty, out_valid=0, out_word=0, out_chan=0, frame_done=0, overflow=0, seq_err=0.
REQ-029 Reset mid-slot discards partial word without setting seq_err; first capture after reset needs a fresh sl.

Configuration
REQ-030 Macro SPECTRO_DESER_PARITY_EN defined: extra output out_parity (1 bit) = even parity (XOR) of out_word, stored per buffer entry; valid with out_valid.
REQ-031 Macro undefined: no out_parity port, no parity storage.

Structure
REQ-032 Package spectro_pkg holds WORD_W default, CHAN_W=4, NUM_CHAN=16, capture-state enumeration.
REQ-033 Buffer is a sub-module sync_fifo (parameterised width/depth, full/empty, same-cycle push/pop); capture FSM stays in top.

Verification
REQ-034 Single slot: sl with selection=5, serial 0xA5C over 12 cycles, out_ready=1 -> out_word=0xA5C, out_chan=5, out_valid one cycle after 12th bit.
REQ-035 Full frame: 16 slots, selection 0..15, word=0x100+index, out_ready=1, then frame_rst -> 16 words in order, chan 0..15, one frame_done pulse, no flags.
REQ-036 Backpressure: out_ready=0 for full frame -> 4 words held (chan 0..3), overflow=1; then drain -> exactly chan 0..3 delivered, out_valid falls.
REQ-037 Early sl: new sl after 5 bits -> seq_err=1, partial dropped, following 12-bit word 0x3C3 delivered correctly; clr_flags -> seq_err=0.
REQ-038 Reset after 7 bits of a slot -> all outputs zero, no word emitted, seq_err=0; next full slot captured correctly.
REQ-039 With SPECTRO_DESER_PARITY_EN: word 0x007 -> out_parity=1, word 0x003 -> out_parity=0.
